// File: rtl/ifetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its prefetch queue.
package ifetch_unit_pkg;

    localparam int unsigned IFETCH_MAX_DEPTH = 16;

    typedef struct packed {
        logic [31:0] ia_plus_4;
        logic [31:0] ir;
    } id_params_t;

    typedef struct packed {
        logic [31:0] ia_plus_4;
        logic [31:0] ir;
    } ifetch_entry_t;

    function automatic id_params_t entry_to_params(ifetch_entry_t e);
        id_params_t p;
        p.ia_plus_4 = e.ia_plus_4;
        p.ir        = e.ir;
        return p;
    endfunction

    function automatic logic [31:0] word_align(logic [31:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch-side bus bundle: instruction memory request/response, decode handoff and redirect.
interface ifetch_unit_if;
    import ifetch_unit_pkg::*;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_data;
    logic        id_valid;
    logic        id_ready;
    id_params_t  id_params;
    logic        branch_req;
    logic [31:0] branch_ia;

    modport master (
        output imem_req, imem_addr, id_valid, id_params,
        input  imem_gnt, imem_rvalid, imem_data, id_ready, branch_req, branch_ia
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_params,
        output imem_gnt, imem_rvalid, imem_data, id_ready, branch_req, branch_ia
    );

endinterface

// File: rtl/ifetch_unit_fetch_fifo.sv
// Prefetch queue: registered storage, flush dominates push/pop, push allowed when full if popping.
module fetch_fifo
    import ifetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush_i,
    input  logic                           push_i,
    input  ifetch_entry_t                  push_data_i,
    input  logic                           pop_i,
    output ifetch_entry_t                  pop_data_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    ifetch_entry_t mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push_ok, pop_ok;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    assign pop_ok  = pop_i & ~empty_o & ~flush_i;
    assign push_ok = push_i & ~flush_i & (~full_o | pop_ok);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign pop_data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: credit-limited requests, in-order response queue, branch flush with drain.
// Optional perf counters enabled by defining MINA_IFETCH_PERF_EN.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_IA = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    ifetch_unit_if.master       fetch_if
`ifdef MINA_IFETCH_PERF_EN
    ,
    output logic [31:0]         perf_fetched,
    output logic [31:0]         perf_dropped
`endif
);

    localparam int unsigned   CW       = $clog2(DEPTH+1);
    localparam logic [CW:0]   DEPTH_C  = (CW+1)'(DEPTH);
    localparam logic [31:0]   RESET_FA = RESET_IA & ~32'h3;

    logic [31:0]   fa_q, fa_d, ra_q, ra_d;
    logic [CW-1:0] out_q, out_d, drop_q, drop_d, fifo_count;
    logic [CW:0]   inflight;
    logic          grant, resp, drop_resp, push, pop, flush;
    logic          fifo_full, fifo_empty;
    ifetch_entry_t push_entry, head_entry;

    // Dropped-but-pending responses stay in out_q so they still consume credit.
    assign inflight = {1'b0, fifo_count} + {1'b0, out_q};
    assign fetch_if.imem_req  = rst_n & ~fetch_if.branch_req & ~fifo_full & (inflight < DEPTH_C);
    assign fetch_if.imem_addr = fa_q;

    assign grant     = fetch_if.imem_req & fetch_if.imem_gnt;
    assign resp      = fetch_if.imem_rvalid;
    assign drop_resp = resp & (fetch_if.branch_req | (drop_q != '0));
    assign push      = resp & ~drop_resp;
    assign pop       = ~fifo_empty & fetch_if.id_ready & ~fetch_if.branch_req;
    assign flush     = fetch_if.branch_req;

    // ra_q tracks the address of the next response that will be kept.
    assign push_entry = '{ia_plus_4: ra_q + 32'd4, ir: fetch_if.imem_data};

    always_comb begin
        out_d  = out_q + CW'(grant) - CW'(resp);
        fa_d   = fa_q;
        ra_d   = ra_q;
        drop_d = drop_q;
        if (fetch_if.branch_req) begin
            fa_d   = word_align(fetch_if.branch_ia);
            ra_d   = word_align(fetch_if.branch_ia);
            drop_d = out_d;
        end else begin
            if (grant)     fa_d   = fa_q + 32'd4;
            if (push)      ra_d   = ra_q + 32'd4;
            if (drop_resp) drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fa_q   <= RESET_FA;
            ra_q   <= RESET_FA;
            out_q  <= '0;
            drop_q <= '0;
        end else begin
            fa_q   <= fa_d;
            ra_q   <= ra_d;
            out_q  <= out_d;
            drop_q <= drop_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fetch_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .pop_data_o  (head_entry),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign fetch_if.id_valid  = ~fifo_empty;
    assign fetch_if.id_params = entry_to_params(head_entry);

`ifdef MINA_IFETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_dropped_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= '0;
            perf_dropped_q <= '0;
        end else begin
            if (pop)       perf_fetched_q <= perf_fetched_q + 32'd1;
            if (drop_resp) perf_dropped_q <= perf_dropped_q + 32'd1;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_dropped = perf_dropped_q;
`endif

endmodule
